// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and physical-memory ports around the LC-3b memory arbiter.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_arbiter_if #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned MASK_W = 2
);
  logic              i_read;
  logic [WORD_W-1:0] i_address;
  logic              i_resp;
  logic [WORD_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [WORD_W-1:0] d_address;
  logic [WORD_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_byte_enable;
  logic              d_resp;
  logic [WORD_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_byte_enable;
  logic              mem_resp;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_resp, i_rdata,
    input  d_read, d_write, d_address, d_wdata, d_byte_enable,
    output d_resp, d_rdata,
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_resp, i_rdata,
    output d_read, d_write, d_address, d_wdata, d_byte_enable,
    input  d_resp, d_rdata,
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter between instruction fetch and data access on the single memory port.
// A grant is held for a whole transaction; ties alternate between the two requesters.
module mem_arbiter #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned MASK_W = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state, state_next;
  grant_t last_grant;

  logic              i_req, d_req;
  logic [WORD_W-1:0] addr_sel, wdata_sel;
  logic [MASK_W-1:0] be_sel;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == SERVE_I) last_grant <= GRANT_I;
      if (state == IDLE && state_next == SERVE_D) last_grant <= GRANT_D;
    end
  end

  // A completed or abandoned transaction always passes through IDLE, so no back-to-back grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_req && (!d_req || last_grant == GRANT_D)) state_next = SERVE_I;
        else if (d_req)                                state_next = SERVE_D;
      end
      SERVE_I: if (bus.mem_resp || !i_req) state_next = IDLE;
      SERVE_D: if (bus.mem_resp || !d_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    addr_sel      = '0;
    wdata_sel     = '0;
    be_sel        = '0;
    bus.i_resp    = 1'b0;
    bus.d_resp    = 1'b0;
    bus.i_rdata   = '0;
    bus.d_rdata   = '0;
    case (state)
      SERVE_I: begin
        bus.mem_read = bus.i_read;
        addr_sel     = bus.i_address;
        bus.i_resp   = bus.mem_resp;
        bus.i_rdata  = bus.mem_rdata;
      end
      SERVE_D: begin
        bus.mem_read  = bus.d_read;
        bus.mem_write = bus.d_write & ~bus.d_read;
        addr_sel      = bus.d_address;
        wdata_sel     = bus.d_wdata;
        be_sel        = bus.d_byte_enable;
        bus.d_resp    = bus.mem_resp;
        bus.d_rdata   = bus.mem_rdata;
      end
      default: ;
    endcase
    bus.mem_address     = addr_sel;
    bus.mem_wdata       = wdata_sel;
    bus.mem_byte_enable = be_sel;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level ownership model checked every cycle,
// plus literal expectations for latency, routing, tie alternation, abort and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_W(16), .MASK_W(2)) bus();

  mem_arbiter #(.WORD_W(16), .MASK_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the memory port (0 none, 1 fetch, 2 data) and who won last.
  int m_owner;
  bit m_fetch_won_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner          <= 0;
      m_fetch_won_last <= 1'b0;
    end else if (m_owner == 0) begin
      if (bus.i_read && (!(bus.d_read || bus.d_write) || !m_fetch_won_last)) begin
        m_owner          <= 1;
        m_fetch_won_last <= 1'b1;
      end else if (bus.d_read || bus.d_write) begin
        m_owner          <= 2;
        m_fetch_won_last <= 1'b0;
      end
    end else if (bus.mem_resp) begin
      m_owner <= 0;
    end else if (m_owner == 1 && !bus.i_read) begin
      m_owner <= 0;
    end else if (m_owner == 2 && !(bus.d_read || bus.d_write)) begin
      m_owner <= 0;
    end
  end

  always @(negedge clk) begin
    chk("mem_read",  bus.mem_read,
        (m_owner == 1) ? bus.i_read : (m_owner == 2) ? bus.d_read : 1'b0);
    chk("mem_write", bus.mem_write, (m_owner == 2) && bus.d_write && !bus.d_read);
    chk("mem_address", bus.mem_address,
        (m_owner == 1) ? bus.i_address : (m_owner == 2) ? bus.d_address : 16'h0);
    chk("mem_wdata", bus.mem_wdata, (m_owner == 2) ? bus.d_wdata : 16'h0);
    chk("mem_be",    bus.mem_byte_enable, (m_owner == 2) ? bus.d_byte_enable : 2'b00);
    chk("i_resp",    bus.i_resp, (m_owner == 1) && bus.mem_resp);
    chk("d_resp",    bus.d_resp, (m_owner == 2) && bus.mem_resp);
    chk("i_rdata",   bus.i_rdata, (m_owner == 1) ? bus.mem_rdata : 16'h0);
    chk("d_rdata",   bus.d_rdata, (m_owner == 2) ? bus.mem_rdata : 16'h0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_strobes"}, {bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp}, 4'b0000);
    chk({name, "_bus"}, {bus.mem_address, bus.mem_wdata}, 32'h0);
    chk({name, "_rdata"}, {bus.i_rdata, bus.d_rdata}, 32'h0);
  endtask

  initial begin
    logic [15:0] order [4];
    logic [15:0] want_order [4];
    bit got;
    want_order = '{16'h00A0, 16'h00D0, 16'h00A0, 16'h00D0};

    bus.i_read = 1'b0; bus.i_address = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_address = '0;
    bus.d_wdata = '0; bus.d_byte_enable = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = 16'hFFFF;

    step(); step();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // Lone fetch: strobe one cycle after request, response three cycles later.
    bus.i_read = 1'b1; bus.i_address = 16'h0040;
    #1 chk("fetch_not_yet", bus.mem_read, 1'b0);
    step();
    chk("fetch_grant", {bus.mem_read, bus.mem_address}, {1'b1, 16'h0040});
    step(); step();
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'h1234;
    #1 chk("fetch_resp", {bus.i_resp, bus.d_resp, bus.i_rdata}, {2'b10, 16'h1234});
    step();
    bus.mem_resp = 1'b0;
    #1 chk("fetch_after", {bus.i_resp, bus.mem_read}, 2'b00);
    bus.i_read = 1'b0;
    step();

    // Data write, requester holds its strobe one cycle past the response.
    bus.d_write = 1'b1; bus.d_address = 16'h0100; bus.d_wdata = 16'hBEEF; bus.d_byte_enable = 2'b01;
    step();
    chk("dwrite_grant",
        {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata, bus.mem_byte_enable},
        {2'b01, 16'h0100, 16'hBEEF, 2'b01});
    step();
    bus.mem_resp = 1'b1;
    #1 chk("dwrite_resp", {bus.d_resp, bus.i_resp}, 2'b10);
    step();
    bus.mem_resp = 1'b0;
    #1 chk("dwrite_gap_idle", bus.mem_write, 1'b0);
    bus.d_write = 1'b0;
    step();

    // Reset asserted in the middle of a data write clears the strobe immediately.
    bus.d_write = 1'b1;
    step();
    chk("pre_reset_write", bus.mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_write", bus.mem_write, 1'b0);
    bus.d_write = 1'b0; bus.d_address = '0; bus.d_wdata = '0; bus.d_byte_enable = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    check_idle_outputs("post_reset");

    // Contention from reset: both held, grants alternate I, D, I, D.
    bus.i_read = 1'b1; bus.i_address = 16'h00A0;
    bus.d_read = 1'b1; bus.d_address = 16'h00D0;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        if (bus.mem_read) got = 1'b1;
        else step();
      end
      chk("tie_grant_seen", got, 1'b1);
      order[n] = bus.mem_address;
      step();
      bus.mem_resp = 1'b1; bus.mem_rdata = 16'h5000 + 16'(n);
      #1;
      if (n % 2 == 0) chk("tie_i_route", {bus.i_resp, bus.d_resp, bus.i_rdata}, {2'b10, 16'h5000 + 16'(n)});
      else            chk("tie_d_route", {bus.i_resp, bus.d_resp, bus.d_rdata}, {2'b01, 16'h5000 + 16'(n)});
      step();
      bus.mem_resp = 1'b0;
      #1 chk("tie_gap_idle", bus.mem_read, 1'b0);
    end
    for (int n = 0; n < 4; n++) chk("tie_order", order[n], want_order[n]);
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    step();

    // Both data strobes: read wins.
    bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 16'h0200;
    step();
    chk("both_strobes", {bus.mem_read, bus.mem_write}, 2'b10);
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'hCAFE;
    #1 chk("both_resp", {bus.d_resp, bus.d_rdata}, {1'b1, 16'hCAFE});
    step();
    bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    step();

    // Abort: fetch drops before response; stray response in IDLE is ignored.
    bus.i_read = 1'b1; bus.i_address = 16'h0300;
    step();
    chk("abort_grant", bus.mem_read, 1'b1);
    step();
    bus.i_read = 1'b0;
    #1 chk("abort_drop", bus.mem_read, 1'b0);
    step();
    bus.mem_resp = 1'b1; bus.mem_rdata = 16'h7777;
    bus.d_read = 1'b1; bus.d_address = 16'h0400;
    #1 chk("stray_resp", {bus.i_resp, bus.d_resp, bus.i_rdata, bus.d_rdata}, 34'h0);
    step();
    bus.mem_resp = 1'b0;
    #1 chk("after_abort_d", {bus.mem_read, bus.mem_address}, {1'b1, 16'h0400});
    bus.mem_resp = 1'b1;
    #1 chk("after_abort_dresp", bus.d_resp, 1'b1);
    step();
    bus.mem_resp = 1'b0; bus.d_read = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
